// File: rtl/jt6295_dec_mix.sv
// OKI ADPCM decoder and 4-channel mixer fed by the time-multiplexed serializer stream.
// Optional JT6295_CHMUTE_EN: per-channel mute of the attenuated contribution via ch_mute.
module jt6295_dec_mix #(
  parameter int OUTW = 14
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   cen4,
  input  logic                   zero,
  input  logic                   pipe_en,
  input  logic [3:0]             pipe_att,
  input  logic [3:0]             pipe_data,
  input  logic [3:0]             ch_mute,
  output logic signed [OUTW-1:0] sound,
  output logic                   sample
);

  function automatic logic [10:0] step_lut(input logic [5:0] idx);
    unique case (idx)
      6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
      6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
      6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
      6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  function automatic logic [5:0] gain_lut(input logic [3:0] att);
    case (att)
      4'd0:    gain_lut = 6'd32;
      4'd1:    gain_lut = 6'd23;
      4'd2:    gain_lut = 6'd16;
      4'd3:    gain_lut = 6'd11;
      4'd4:    gain_lut = 6'd8;
      4'd5:    gain_lut = 6'd4;
      4'd6:    gain_lut = 6'd2;
      4'd7:    gain_lut = 6'd1;
      default: gain_lut = 6'd0;
    endcase
  endfunction

  logic [1:0]        pslot;
  logic [1:0]        pch;
  logic [5:0]        idx_q [4];
  logic signed [11:0] sig_q [4];

  logic [10:0]        step;
  logic [11:0]        delta;
  logic signed [13:0] sig_sum;
  logic signed [7:0]  idx_sum;
  logic signed [7:0]  idx_adj;
  logic signed [11:0] new_sig;
  logic [5:0]         new_idx;

  logic signed [11:0]     dec_s;
  logic [3:0]             dec_att;
  logic [1:0]             dec_slot;
  logic signed [17:0]     prod;
  logic signed [12:0]     att_s;
  logic signed [12:0]     att_m;
  logic signed [OUTW-1:0] acc;
  logic signed [OUTW-1:0] acc_base;
  logic signed [OUTW-1:0] acc_sum;

  // zero tags channel 3 on the pipe, so the slot count realigns every frame
  assign pch = zero ? 2'd3 : pslot;

  always_comb begin
    step  = step_lut(idx_q[0]);
    delta = {4'd0, step[10:3]}
          + (pipe_data[2] ? {1'b0, step}        : 12'd0)
          + (pipe_data[1] ? {2'd0, step[10:1]}  : 12'd0)
          + (pipe_data[0] ? {3'd0, step[10:2]}  : 12'd0);
    sig_sum = pipe_data[3] ? ({{2{sig_q[0][11]}}, sig_q[0]} - {2'b00, delta})
                           : ({{2{sig_q[0][11]}}, sig_q[0]} + {2'b00, delta});
    if (sig_sum > 14'sd2047)       new_sig = 12'sd2047;
    else if (sig_sum < -14'sd2048) new_sig = -12'sd2048;
    else                           new_sig = sig_sum[11:0];

    case (pipe_data[2:0])
      3'd4:    idx_adj = 8'sd2;
      3'd5:    idx_adj = 8'sd4;
      3'd6:    idx_adj = 8'sd6;
      3'd7:    idx_adj = 8'sd8;
      default: idx_adj = -8'sd1;
    endcase
    idx_sum = $signed({2'b00, idx_q[0]}) + idx_adj;
    if (idx_sum < 8'sd0)       new_idx = 6'd0;
    else if (idx_sum > 8'sd48) new_idx = 6'd48;
    else                       new_idx = idx_sum[5:0];

    // an idle channel restarts from silence
    if (!pipe_en) begin
      new_sig = 12'sd0;
      new_idx = 6'd0;
    end
  end

  always_comb begin
    prod  = dec_s * $signed({1'b0, gain_lut(dec_att)});
    att_s = prod[17:5];
`ifdef JT6295_CHMUTE_EN
    att_m = ch_mute[dec_slot] ? 13'sd0 : att_s;
`else
    att_m = att_s;
`endif
    acc_base = (dec_slot == 2'd0) ? '0 : acc;
    acc_sum  = acc_base + OUTW'(att_m);
  end

`ifndef JT6295_CHMUTE_EN
  logic unused_ch_mute;
  assign unused_ch_mute = ^ch_mute;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pslot    <= 2'd0;
      dec_s    <= '0;
      dec_att  <= '0;
      dec_slot <= '0;
      acc      <= '0;
      sound    <= '0;
      sample   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        idx_q[i] <= '0;
        sig_q[i] <= '0;
      end
    end else begin
      sample <= 1'b0;
      if (cen4) begin
        pslot <= zero ? 2'd0 : pslot + 2'd1;
        for (int i = 0; i < 3; i++) begin
          idx_q[i] <= idx_q[i+1];
          sig_q[i] <= sig_q[i+1];
        end
        idx_q[3] <= new_idx;
        sig_q[3] <= new_sig;
        dec_s    <= new_sig;
        dec_att  <= pipe_att;
        dec_slot <= pch;
        acc      <= acc_sum;
        if (dec_slot == 2'd3) begin
          sound  <= acc_sum;
          sample <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt6295_dec_mix.sv
// Directed bench for jt6295_dec_mix: hand-computed mixed samples per frame.
module tb_jt6295_dec_mix;

  logic              rst;
  logic              clk;
  logic              cen4;
  logic              zero;
  logic              pipe_en;
  logic [3:0]        pipe_att;
  logic [3:0]        pipe_data;
  logic [3:0]        ch_mute;
  logic signed [13:0] sound;
  logic              sample;

  int checks = 0;
  int errors = 0;
  logic sample_seen;

  jt6295_dec_mix #(.OUTW(14)) dut (
    .rst       (rst),
    .clk       (clk),
    .cen4      (cen4),
    .zero      (zero),
    .pipe_en   (pipe_en),
    .pipe_att  (pipe_att),
    .pipe_data (pipe_data),
    .ch_mute   (ch_mute),
    .sound     (sound),
    .sample    (sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cen4 = 1'b0;
    zero = 1'b0;
    pipe_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sample_seen = 1'b0;
    @(negedge clk);
  endtask

  task automatic slot(input logic en, input logic [3:0] att, input logic [3:0] nib,
                      input logic z);
    @(negedge clk);
    pipe_en = en;
    pipe_att = att;
    pipe_data = nib;
    zero = z;
    cen4 = 1'b1;
    @(negedge clk);
    if (sample) sample_seen = 1'b1;
    cen4 = 1'b0;
    zero = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input logic [3:0] en, input logic [15:0] att, input logic [15:0] nib);
    for (int c = 0; c < 4; c++) slot(en[c], att[4*c +: 4], nib[4*c +: 4], c == 3);
  endtask

  task automatic flush();
    frame(4'b0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; cen4 = 1'b0; zero = 1'b0; pipe_en = 1'b0;
    pipe_att = '0; pipe_data = '0; ch_mute = '0; sample_seen = 1'b0;
    #23;
    check("rst_sound", int'(sound), 0);
    check("rst_sample", int'(sample), 0);
    do_reset();

    // ch0 nibble 0 from reset
    frame(4'b0001, 16'h0000, 16'h0000);
    flush();
    check("ch0_nib0", int'(sound), 2);
    check("sample_pulse", int'(sample_seen), 1);
    check("sample_low", int'(sample), 0);

    // ch0 0x7 twice: 30 then 93
    do_reset();
    frame(4'b0001, 16'h0000, 16'h0007);
    frame(4'b0001, 16'h0000, 16'h0007);
    check("ch0_7_first", int'(sound), 30);
    flush();
    check("ch0_7_second", int'(sound), 93);

    // negative decode and floor rounding
    do_reset();
    frame(4'b0001, 16'h0000, 16'h0008);
    flush();
    check("ch0_8_att0", int'(sound), -2);
    do_reset();
    frame(4'b0001, 16'h0001, 16'h0008);
    flush();
    check("ch0_8_att1", int'(sound), -2);

    // all channels, mute on ch1 only effective with the optional build
    ch_mute = 4'b0010;
    do_reset();
    frame(4'b1111, 16'h0000, 16'h7777);
    flush();
`ifdef JT6295_CHMUTE_EN
    check("all7_mute1", int'(sound), 90);
`else
    check("all7_mute1", int'(sound), 120);
`endif
    ch_mute = 4'b0000;
    do_reset();
    frame(4'b1111, 16'h1111, 16'h7777);
    flush();
    check("all7_att1", int'(sound), 84);
    do_reset();
    frame(4'b1111, 16'h7420, 16'h7777);
    flush();
    check("all7_mixatt", int'(sound), 52);
    do_reset();
    frame(4'b1111, 16'h0000, 16'hFFFF);
    flush();
    check("allF_att0", int'(sound), -120);
    do_reset();
    frame(4'b0001, 16'h0008, 16'h0007);
    flush();
    check("ch0_att8", int'(sound), 0);

    // ch2 saturation, then idle, then restart
    do_reset();
    for (int i = 0; i < 40; i++) begin
      frame(4'b0100, 16'h0000, 16'h0700);
      if (i == 1) check("ch2_early", int'(sound), 30);
    end
    check("ch2_sat39", int'(sound), 2047);
    frame(4'b0000, 16'h0000, 16'h0700);
    check("ch2_sat40", int'(sound), 2047);
    frame(4'b0100, 16'h0000, 16'h0000);
    check("ch2_idle", int'(sound), 0);
    flush();
    check("ch2_restart", int'(sound), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
